// File: rtl/el2_pkg.sv
// Shared EL2 core types: dec trigger config and LSU pipeline packet.
// Also carries the default hit-counter width for the LSU trigger unit.
package el2_pkg;

  typedef struct packed {
    logic        select;
    logic        match;
    logic        store;
    logic        load;
    logic        execute;
    logic        m;
    logic [31:0] tdata2;
  } el2_trigger_pkt_t;

  typedef struct packed {
    logic fast_int;
    logic stack;
    logic by;
    logic half;
    logic word;
    logic dword;
    logic load;
    logic store;
    logic unsign;
    logic dma;
    logic store_data_bypass_d;
    logic load_ldst_bypass_d;
    logic store_data_bypass_m;
    logic valid;
  } el2_lsu_pkt_t;

  localparam int LSU_TRIG_CNT_W = 8;

endpackage

// File: rtl/el2_lsu_trigger_seq_if.sv
// M-stage access bus into the LSU trigger unit, with the combinational
// per-trigger fire vector returned to the access side.
interface el2_lsu_trigger_seq_if #(
  parameter int NUM_TRIG = 4
) ();
  import el2_pkg::*;

  el2_lsu_pkt_t          lsu_pkt_m;
  logic [31:0]           lsu_addr_m;
  logic [31:0]           store_data_m;
  logic                  lsu_flush_m;
  logic [NUM_TRIG-1:0]   lsu_trigger_match_m;

  modport master (
    output lsu_pkt_m, lsu_addr_m, store_data_m, lsu_flush_m,
    input  lsu_trigger_match_m
  );

  modport slave (
    input  lsu_pkt_m, lsu_addr_m, store_data_m, lsu_flush_m,
    output lsu_trigger_match_m
  );
endinterface

// File: rtl/el2_lsu_trig_cnt.sv
// One trigger's hit counter, fire (ev) generation and sticky hit status.
// cand_i may fire combinationally; state only advances when upd_i is high.
module el2_lsu_trig_cnt
  import el2_pkg::*;
#(
  parameter int CNT_W = LSU_TRIG_CNT_W
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             cand_i,
  input  logic             upd_i,
  input  logic             match_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] thresh_i,
  output logic             ev_o,
  output logic             hit_r_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_r_q, hit_r_d;
  logic             at_thresh;

  // thresh 0 and 1 both mean fire on every hit; a counter left above a
  // lowered threshold keeps counting and wraps round to it.
  assign at_thresh = (thresh_i <= CNT_W'(1)) | (cnt_q == thresh_i - CNT_W'(1));
  assign ev_o      = cand_i & at_thresh;
  assign hit_r_o   = hit_r_q;

  always_comb begin
    cnt_d   = cnt_q;
    hit_r_d = hit_r_q;
    if (cand_i && upd_i) begin
      cnt_d = ev_o ? '0 : cnt_q + CNT_W'(1);
    end
    if (match_i && upd_i) begin
      hit_r_d = 1'b1;
    end
    if (clr_i) begin
      cnt_d   = '0;
      hit_r_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_q   <= '0;
      hit_r_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      hit_r_q <= hit_r_d;
    end
  end
endmodule

// File: rtl/rvmaskandmatch.sv
// Mask-and-match: exact compare, or with masken the trailing ones of mask
// plus the next bit up become don't-care (an all-ones mask stays exact).
module rvmaskandmatch #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] mask,
  input  logic [WIDTH-1:0] data,
  input  logic             masken,
  output logic             match
);
  logic [WIDTH-1:0] matchvec;
  logic             masken_or_fullmask;

  assign masken_or_fullmask = masken & ~(&mask);
  assign matchvec[0]        = masken_or_fullmask | (mask[0] == data[0]);

  for (genvar i = 1; i < WIDTH; i++) begin : g_bit
    assign matchvec[i] = (masken_or_fullmask & (&mask[i-1:0])) | (mask[i] == data[i]);
  end

  assign match = &matchvec;
endmodule

// File: rtl/el2_lsu_trigger_seq.sv
// M-stage LSU debug triggers: address/store-data mask-match, per-trigger hit
// counting and paired arm/fire sequencing; match_m is combinational.
module el2_lsu_trigger_seq
  import el2_pkg::*;
#(
  parameter int NUM_TRIG = 4,
  parameter int CNT_W    = LSU_TRIG_CNT_W
) (
  input  logic                           clk,
  input  logic                           rst_l,
  input  el2_trigger_pkt_t [NUM_TRIG-1:0] trigger_pkt_any,
  input  logic [NUM_TRIG-1:0][CNT_W-1:0] count_thresh,
  input  logic [NUM_TRIG/2-1:0]          seq_en,
  input  logic [NUM_TRIG-1:0]            trig_clr,
  el2_lsu_trigger_seq_if.slave           lsu_if,
  output logic [NUM_TRIG-1:0]            lsu_trigger_hit_r,
  output logic [NUM_TRIG/2-1:0]          lsu_trigger_armed
);
  localparam int NP = NUM_TRIG / 2;

  el2_lsu_pkt_t                 pkt;
  logic [31:0]                  sd;
  logic                         upd;
  logic                         trig_en;
  logic [31:0]                  addr_op;
  logic [31:0]                  sdata_op;
  logic [NUM_TRIG-1:0]          m_vec;
  logic [NUM_TRIG-1:0]          exec_vec;
  logic [NUM_TRIG-1:0][31:0]    operand;
  logic [NUM_TRIG-1:0]          mm;
  logic [NUM_TRIG-1:0]          raw;
  logic [NUM_TRIG-1:0]          cand;
  logic [NUM_TRIG-1:0]          ev;
  logic [NUM_TRIG-1:0]          match_m;
  logic [NP-1:0]                armed_q, armed_d;
  logic                         unused_bits;

  assign pkt = lsu_if.lsu_pkt_m;
  assign sd  = lsu_if.store_data_m;
  assign upd = ~lsu_if.lsu_flush_m;

  always_comb begin
    m_vec    = '0;
    exec_vec = '0;
    for (int i = 0; i < NUM_TRIG; i++) begin
      m_vec[i]    = trigger_pkt_any[i].m;
      exec_vec[i] = trigger_pkt_any[i].execute;
    end
  end

  // With every trigger disabled the comparators see a constant zero operand.
  assign trig_en  = |m_vec;
  assign addr_op  = trig_en ? lsu_if.lsu_addr_m : 32'h0;
  assign sdata_op = trig_en ? {pkt.word ? sd[31:16] : 16'h0,
                               (pkt.half | pkt.word) ? sd[15:8] : 8'h0,
                               sd[7:0]} : 32'h0;

  for (genvar g = 0; g < NUM_TRIG; g++) begin : g_trig
    assign operand[g] = !trigger_pkt_any[g].select ? addr_op :
                        (trigger_pkt_any[g].store ? sdata_op : 32'h0);

    rvmaskandmatch #(.WIDTH(32)) u_mm (
      .mask   (trigger_pkt_any[g].tdata2),
      .data   (operand[g]),
      .masken (trigger_pkt_any[g].match),
      .match  (mm[g])
    );

    assign raw[g] = pkt.valid & ~pkt.dma & trig_en &
                    ((pkt.store & trigger_pkt_any[g].store) |
                     (pkt.load & trigger_pkt_any[g].load & ~trigger_pkt_any[g].select)) &
                    mm[g];

    // In sequence mode the even trigger only arms, and the odd one neither
    // counts nor fires until its pair has been armed on an earlier cycle.
    if (g % 2 == 1) begin : g_odd
      assign cand[g]    = raw[g] & trigger_pkt_any[g].m & (~seq_en[g/2] | armed_q[g/2]);
      assign match_m[g] = ev[g];
    end else begin : g_even
      assign cand[g]    = raw[g] & trigger_pkt_any[g].m;
      assign match_m[g] = ev[g] & ~seq_en[g/2];
    end

    el2_lsu_trig_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst_l    (rst_l),
      .cand_i   (cand[g]),
      .upd_i    (upd),
      .match_i  (match_m[g]),
      .clr_i    (trig_clr[g]),
      .thresh_i (count_thresh[g]),
      .ev_o     (ev[g]),
      .hit_r_o  (lsu_trigger_hit_r[g])
    );
  end

  // Re-arm wins over consume when both triggers of a pair fire together.
  always_comb begin
    armed_d = armed_q;
    for (int p = 0; p < NP; p++) begin
      if (seq_en[p] && upd) begin
        if (ev[2*p]) begin
          armed_d[p] = 1'b1;
        end else if (match_m[2*p+1]) begin
          armed_d[p] = 1'b0;
        end
      end
      if (trig_clr[2*p] || trig_clr[2*p+1]) begin
        armed_d[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      armed_q <= '0;
    end else begin
      armed_q <= armed_d;
    end
  end

  assign lsu_if.lsu_trigger_match_m = match_m;
  assign lsu_trigger_armed          = armed_q;

  assign unused_bits = ^{exec_vec, pkt.fast_int, pkt.stack, pkt.by, pkt.dword, pkt.unsign,
                         pkt.store_data_bypass_d, pkt.load_ldst_bypass_d,
                         pkt.store_data_bypass_m};
endmodule

// File: tb/tb_el2_lsu_trigger_seq.sv
// Directed and randomized checks of el2_lsu_trigger_seq against a
// behavioural model of the trigger rules.
module tb_el2_lsu_trigger_seq;
  import el2_pkg::*;

  localparam int NT = 4;
  localparam int NP = 2;
  localparam int CW = 8;

  logic                    clk = 1'b0;
  logic                    rst_l;
  el2_trigger_pkt_t [NT-1:0] tp;
  logic [NT-1:0][CW-1:0]   thr;
  logic [NP-1:0]           seq_en;
  logic [NT-1:0]           trig_clr;
  logic [NT-1:0]           hit_r;
  logic [NP-1:0]           armed;

  el2_lsu_trigger_seq_if #(.NUM_TRIG(NT)) lsu_if ();

  el2_lsu_trigger_seq #(.NUM_TRIG(NT), .CNT_W(CW)) dut (
    .clk               (clk),
    .rst_l             (rst_l),
    .trigger_pkt_any   (tp),
    .count_thresh      (thr),
    .seq_en            (seq_en),
    .trig_clr          (trig_clr),
    .lsu_if            (lsu_if.slave),
    .lsu_trigger_hit_r (hit_r),
    .lsu_trigger_armed (armed)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cnt_m  [NT];
  bit          hitr_m [NT];
  bit          armed_m[NP];
  bit          cand_m [NT];
  bit          fire_m [NT];
  logic [NT-1:0] exp_match;
  logic [NT-1:0] last_match;
  logic [31:0] pool [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit mm_model(input logic [31:0] t, input logic [31:0] d, input bit napot);
    int          k;
    logic [63:0] care;
    if (!napot) return (t == d);
    k = 0;
    while (k < 32 && t[k]) k++;
    care = ~((64'd1 << (k + 1)) - 64'd1);
    return ((t ^ d) & care[31:0]) == 32'h0;
  endfunction

  function automatic void model_eval(input el2_lsu_pkt_t p, input logic [31:0] addr,
                                     input logic [31:0] sd);
    bit          en;
    bit          raw;
    logic [31:0] sdv;
    logic [31:0] opnd;
    int          t;
    en = 0;
    for (int i = 0; i < NT; i++) en |= tp[i].m;
    if (p.by)        sdv = sd & 32'h0000_00FF;
    else if (p.half) sdv = sd & 32'h0000_FFFF;
    else             sdv = sd;
    for (int i = 0; i < NT; i++) begin
      opnd = !tp[i].select ? addr : (tp[i].store ? sdv : 32'h0);
      raw = p.valid && !p.dma && en &&
            ((p.store && tp[i].store) || (p.load && tp[i].load && !tp[i].select)) &&
            mm_model(tp[i].tdata2, opnd, tp[i].match);
      cand_m[i] = raw && tp[i].m;
      if ((i % 2 == 1) && seq_en[i/2] && !armed_m[i/2]) cand_m[i] = 0;
      t = int'(thr[i]);
      fire_m[i]    = cand_m[i] && (t <= 1 || cnt_m[i] == t - 1);
      exp_match[i] = fire_m[i] && !((i % 2 == 0) && seq_en[i/2]);
    end
  endfunction

  function automatic void model_update(input bit flush, input logic [NT-1:0] clr);
    if (!flush) begin
      for (int i = 0; i < NT; i++) begin
        if (cand_m[i]) cnt_m[i] = fire_m[i] ? 0 : (cnt_m[i] + 1) % (1 << CW);
        if (exp_match[i]) hitr_m[i] = 1;
      end
      for (int p = 0; p < NP; p++) begin
        if (seq_en[p]) begin
          if (fire_m[2*p]) armed_m[p] = 1;
          else if (exp_match[2*p+1]) armed_m[p] = 0;
        end
      end
    end
    for (int i = 0; i < NT; i++) if (clr[i]) begin cnt_m[i] = 0; hitr_m[i] = 0; end
    for (int p = 0; p < NP; p++) if (clr[2*p] || clr[2*p+1]) armed_m[p] = 0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NT; i++) begin cnt_m[i] = 0; hitr_m[i] = 0; end
    for (int p = 0; p < NP; p++) armed_m[p] = 0;
  endfunction

  task automatic check_state(input string tag);
    logic [NT-1:0] eh;
    logic [NP-1:0] ea;
    for (int i = 0; i < NT; i++) eh[i] = hitr_m[i];
    for (int p = 0; p < NP; p++) ea[p] = armed_m[p];
    check({tag, "_hit_r"}, hit_r, eh);
    check({tag, "_armed"}, armed, ea);
  endtask

  // Drive one cycle of M-stage activity (sz: 0 byte, 1 half, 2 word).
  task automatic access(input bit ld, input bit st, input int sz, input logic [31:0] addr,
                        input logic [31:0] sd, input bit dma, input bit flush,
                        input logic [NT-1:0] clr);
    el2_lsu_pkt_t p;
    p       = '0;
    p.valid = ld | st;
    p.load  = ld;
    p.store = st;
    p.by    = (sz == 0);
    p.half  = (sz == 1);
    p.word  = (sz == 2);
    p.dma   = dma;
    lsu_if.lsu_pkt_m    = p;
    lsu_if.lsu_addr_m   = addr;
    lsu_if.store_data_m = sd;
    lsu_if.lsu_flush_m  = flush;
    trig_clr            = clr;
    #1;
    model_eval(p, addr, sd);
    last_match = lsu_if.lsu_trigger_match_m;
    check("match_m", last_match, exp_match);
    @(posedge clk);
    #1;
    model_update(flush, clr);
    check_state("post");
    lsu_if.lsu_pkt_m   = '0;
    lsu_if.lsu_flush_m = 1'b0;
    trig_clr           = '0;
  endtask

  task automatic idle(input logic [NT-1:0] clr);
    access(0, 0, 2, 32'h0, 32'h0, 0, 0, clr);
  endtask

  task automatic set_trig(input int i, input bit sel, input bit napot, input bit st,
                          input bit ld, input bit m, input logic [31:0] t2);
    tp[i]         = '0;
    tp[i].select  = sel;
    tp[i].match   = napot;
    tp[i].store   = st;
    tp[i].load    = ld;
    tp[i].m       = m;
    tp[i].tdata2  = t2;
  endtask

  initial begin
    rst_l               = 1'b0;
    tp                  = '0;
    thr                 = '0;
    seq_en              = '0;
    trig_clr            = '0;
    lsu_if.lsu_pkt_m    = '0;
    lsu_if.lsu_addr_m   = '0;
    lsu_if.store_data_m = '0;
    lsu_if.lsu_flush_m  = 1'b0;
    model_reset();
    pool[0] = 32'h8000_1000;
    pool[1] = 32'h8000_10F3;
    pool[2] = 32'h0000_00A7;
    pool[3] = 32'h0000_12A5;

    #12;
    check("reset_hit_r", hit_r, 0);
    check("reset_armed", armed, 0);
    check("reset_match", lsu_if.lsu_trigger_match_m, 0);
    rst_l = 1'b1;
    @(posedge clk);
    #1;

    // Exact address match on a load.
    set_trig(0, 0, 0, 0, 1, 1, 32'h8000_1000);
    access(1, 0, 2, 32'h8000_1000, 32'h0, 0, 0, '0);
    check("exact_hit", last_match[0], 1);
    check("exact_hit_r", hit_r[0], 1);
    access(1, 0, 2, 32'h8000_1004, 32'h0, 0, 0, '0);
    check("exact_miss", last_match[0], 0);

    // NAPOT match on store data, with size masking of the operand.
    set_trig(0, 1, 1, 1, 0, 1, 32'h0000_00A7);
    access(0, 1, 0, 32'h1234_5678, 32'h5566_77A5, 0, 0, '0);
    check("napot_a5", last_match[0], 1);
    access(0, 1, 0, 32'h1234_5678, 32'h0000_00B5, 0, 0, '0);
    check("napot_b5", last_match[0], 0);
    access(0, 1, 1, 32'h1234_5678, 32'h0000_12A5, 0, 0, '0);
    check("napot_half", last_match[0], 0);

    // Threshold 3 on trigger 2, with a flushed hit in between.
    tp[0] = '0;
    set_trig(2, 0, 0, 0, 1, 1, 32'h8000_2000);
    thr[2] = 8'd3;
    idle(4'b0100);
    access(1, 0, 2, 32'h8000_2000, 32'h0, 0, 0, '0);
    access(1, 0, 2, 32'h8000_2000, 32'h0, 0, 0, '0);
    check("cnt_2nd", last_match[2], 0);
    idle('0);
    access(1, 0, 2, 32'h8000_2000, 32'h0, 0, 1, '0);
    access(1, 0, 2, 32'h8000_2000, 32'h0, 0, 0, '0);
    check("cnt_3rd", last_match[2], 1);
    access(1, 0, 2, 32'h8000_2000, 32'h0, 0, 0, '0);
    access(1, 0, 2, 32'h8000_2000, 32'h0, 0, 0, '0);
    idle(4'b0100);
    check("clr_hit_r", hit_r[2], 0);
    access(1, 0, 2, 32'h8000_2000, 32'h0, 0, 0, '0);
    access(1, 0, 2, 32'h8000_2000, 32'h0, 0, 0, '0);
    check("clr_2nd", last_match[2], 0);
    access(1, 0, 2, 32'h8000_2000, 32'h0, 0, 0, '0);
    check("clr_3rd", last_match[2], 1);

    // Pair 0 sequencing.
    set_trig(0, 0, 0, 0, 1, 1, 32'h8000_3000);
    set_trig(1, 0, 0, 0, 1, 1, 32'h8000_3100);
    seq_en = 2'b01;
    idle(4'b0011);
    access(1, 0, 2, 32'h8000_3100, 32'h0, 0, 0, '0);
    check("seq_t1_first", last_match[1:0], 0);
    check("seq_t1_armed", armed[0], 0);
    access(1, 0, 2, 32'h8000_3000, 32'h0, 0, 0, '0);
    check("seq_arm_match", last_match[0], 0);
    check("seq_armed", armed[0], 1);
    idle('0);
    access(1, 0, 2, 32'h8000_3100, 32'h0, 0, 0, '0);
    check("seq_fire", last_match[1], 1);
    check("seq_disarm", armed[0], 0);

    // Same-cycle arm and fire.
    set_trig(1, 0, 0, 0, 1, 1, 32'h8000_3000);
    access(1, 0, 2, 32'h8000_3000, 32'h0, 0, 0, '0);
    check("same_nofire", last_match[1:0], 0);
    check("same_armed", armed[0], 1);
    access(1, 0, 2, 32'h8000_3000, 32'h0, 0, 0, '0);
    check("same_fire", last_match[1], 1);
    check("same_rearm", armed[0], 1);

    // Asynchronous reset in the middle of a count.
    access(1, 0, 2, 32'h8000_2000, 32'h0, 0, 0, '0);
    access(1, 0, 2, 32'h8000_2000, 32'h0, 0, 0, '0);
    #2;
    rst_l = 1'b0;
    #1;
    check("arst_hit_r", hit_r, 0);
    check("arst_armed", armed, 0);
    model_reset();
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;
    access(1, 0, 2, 32'h8000_2000, 32'h0, 1, 0, '0);
    check("dma_nomatch", last_match, 0);
    tp[2].m = 1'b0;
    access(1, 0, 2, 32'h8000_2000, 32'h0, 0, 0, '0);
    check("m0_nomatch", last_match[2], 0);
    tp[2].m = 1'b1;
    access(1, 0, 2, 32'h8000_2000, 32'h0, 0, 0, '0);
    access(1, 0, 2, 32'h8000_2000, 32'h0, 0, 0, '0);
    check("post_rst_2nd", last_match[2], 0);
    access(1, 0, 2, 32'h8000_2000, 32'h0, 0, 0, '0);
    check("post_rst_3rd", last_match[2], 1);

    // Randomized traffic, reconfiguring without clearing state.
    for (int n = 0; n < 500; n++) begin
      logic [31:0] a;
      logic [31:0] d;
      int          kind;
      if (n % 25 == 0) begin
        for (int i = 0; i < NT; i++) begin
          set_trig(i, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 4) != 0, pool[$urandom_range(0, 3)]);
          thr[i] = CW'($urandom_range(0, 3));
        end
        seq_en = NP'($urandom_range(0, 3));
      end
      a = pool[$urandom_range(0, 3)] ^ ($urandom_range(0, 2) == 0 ? 32'h0 : 32'($urandom_range(0, 15)));
      d = pool[$urandom_range(0, 3)] ^ ($urandom_range(0, 2) == 0 ? 32'h0 : 32'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1) d[31:16] = 16'($urandom);
      kind = $urandom_range(0, 3);
      access(kind == 1 || kind == 3, kind == 2, $urandom_range(0, 2), a, d,
             $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
             ($urandom_range(0, 15) == 0) ? NT'($urandom_range(1, 15)) : '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
